hazard_control: RTL and testbench

HAZARD_CONTROL -- requirements
Module: hazard_control

---
 rtl/mips_defs.sv | 21 ++
 rtl/load_use_detect.sv | 35 +++
 rtl/hazard_control.sv | 118 +++++++++++
 tb/tb_hazard_control.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: opcode/funct constants used by hazard
// detection and the state encoding of the hazard-control FSM.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LDSTALL = 2'd1,
    BUSY    = 2'd2
  } hc_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator.
//   InstrID       : instruction in IF/ID
//   IDEX_MemRead  : ID/EX instruction is a load
//   IDEX_WriteReg : destination of the ID/EX instruction
//   Hazard        : IF/ID instruction reads the register being loaded
module load_use_detect
  import mips_defs::*;
(
  input  logic [31:0] InstrID,
  input  logic        IDEX_MemRead,
  input  logic [4:0]  IDEX_WriteReg,
  output logic        Hazard
);

  logic [5:0] w_op;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic       w_rt_src;
  logic       w_unused_lo;

  assign w_op        = InstrID[31:26];
  assign w_rs        = InstrID[25:21];
  assign w_rt        = InstrID[20:16];
  assign w_unused_lo = ^InstrID[15:0];

  // rt is only read by R-type, stores and compare-branches; elsewhere it
  // is a destination and must not raise a hazard.
  assign w_rt_src = (w_op == OP_RTYPE) || (w_op == OP_SW) ||
                    (w_op == OP_BEQ)   || (w_op == OP_BNE);

  assign Hazard = IDEX_MemRead && (IDEX_WriteReg != 5'd0) &&
                  ((IDEX_WriteReg == w_rs) ||
                   (w_rt_src && (IDEX_WriteReg == w_rt)));

endmodule

// File: rtl/hazard_control.sv
// Pipeline hazard control: load-use stall, HI/LO mult/div occupancy and
// branch flush.
//   Clk, Reset    : clock, synchronous active-high reset
//   InstrID       : instruction in IF/ID
//   IDEX_MemRead  : ID/EX holds a load
//   IDEX_WriteReg : ID/EX destination register
//   BranchTaken   : branch/jump taken in EX
//   MulDivStart   : mult/div issues from ID
//   Stall/PCWrite : hold IF/ID / PC enable (PCWrite = ~Stall)
//   Flush         : clear IF/ID
//   IDEX_Bubble   : zero control bits entering ID/EX
//   MulDivBusy    : HI/LO unit occupied
module hazard_control
  import mips_defs::*;
#(
  parameter int unsigned MULDIV_LATENCY = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] InstrID,
  input  logic        IDEX_MemRead,
  input  logic [4:0]  IDEX_WriteReg,
  input  logic        BranchTaken,
  input  logic        MulDivStart,
  output logic        Stall,
  output logic        PCWrite,
  output logic        Flush,
  output logic        IDEX_Bubble,
  output logic        MulDivBusy
);

  localparam logic [3:0] CNT_LOAD = 4'(MULDIV_LATENCY - 1);

  hc_state_t  r_state;
  hc_state_t  w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       r_busy;
  logic       w_busy_nxt;

  logic       w_hazard_raw;
  logic       w_load_use;
  logic       w_md_stall;
  logic       w_start;
  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic       w_is_hilo_rd;
  logic       w_is_muldiv;

  load_use_detect u_load_use_detect (
    .InstrID       (InstrID),
    .IDEX_MemRead  (IDEX_MemRead),
    .IDEX_WriteReg (IDEX_WriteReg),
    .Hazard        (w_hazard_raw)
  );

  assign w_op         = InstrID[31:26];
  assign w_funct      = InstrID[5:0];
  assign w_is_hilo_rd = (w_op == OP_RTYPE) &&
                        ((w_funct == FN_MFHI) || (w_funct == FN_MFLO));
  assign w_is_muldiv  = (w_op == OP_RTYPE) &&
                        ((w_funct == FN_MULT) || (w_funct == FN_DIV));

  // Busy is tracked apart from the FSM state so a load-use stall taken
  // while the HI/LO unit runs does not lose the occupancy. HI/LO readers
  // are released in the final busy cycle (counter at 0).
  always_comb begin
    w_load_use  = w_hazard_raw && (r_state != LDSTALL);
    w_md_stall  = r_busy && (r_cnt != '0) &&
                  (w_is_hilo_rd || (w_is_muldiv && MulDivStart));
    w_start     = MulDivStart && !BranchTaken && !w_load_use && !w_md_stall;

    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = 1'b0;
    if (w_start) begin
      w_cnt_nxt  = CNT_LOAD;
      w_busy_nxt = 1'b1;
    end else if (r_busy && (r_cnt != '0)) begin
      w_cnt_nxt  = r_cnt - 4'd1;
      w_busy_nxt = 1'b1;
    end

    w_state_nxt = w_busy_nxt ? BUSY : IDLE;
    if (w_load_use && !BranchTaken) begin
      w_state_nxt = LDSTALL;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    Stall       = 1'b0;
    Flush       = 1'b0;
    IDEX_Bubble = 1'b0;
    if (Reset) begin
      Stall       = 1'b0;
    end else if (BranchTaken) begin
      Flush       = 1'b1;
      IDEX_Bubble = 1'b1;
    end else if (w_load_use || w_md_stall) begin
      Stall       = 1'b1;
      IDEX_Bubble = 1'b1;
    end
    PCWrite    = !Stall;
    MulDivBusy = r_busy && !Reset;
  end

endmodule

// File: tb/tb_hazard_control.sv
module tb_hazard_control;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] InstrID;
  logic        IDEX_MemRead;
  logic [4:0]  IDEX_WriteReg;
  logic        BranchTaken;
  logic        MulDivStart;
  logic        Stall;
  logic        PCWrite;
  logic        Flush;
  logic        IDEX_Bubble;
  logic        MulDivBusy;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  // Output vector order: {Stall, PCWrite, Flush, IDEX_Bubble, MulDivBusy}
  localparam logic [4:0] OK  = 5'b01000;
  localparam logic [4:0] STL = 5'b10010;
  localparam logic [4:0] FLS = 5'b01110;
  localparam logic [4:0] BSY = 5'b00001;

  hazard_control #(.MULDIV_LATENCY(4)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .InstrID       (InstrID),
    .IDEX_MemRead  (IDEX_MemRead),
    .IDEX_WriteReg (IDEX_WriteReg),
    .BranchTaken   (BranchTaken),
    .MulDivStart   (MulDivStart),
    .Stall         (Stall),
    .PCWrite       (PCWrite),
    .Flush         (Flush),
    .IDEX_Bubble   (IDEX_Bubble),
    .MulDivBusy    (MulDivBusy)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] rtyp(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] ityp(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt);
    return {op, rs, rt, 16'h0004};
  endfunction

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got {stall,pcw,flush,bub,busy}=%b want %b", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs, check the combinational outputs mid-cycle,
  // then advance past the next rising edge.
  task automatic vec(input string tag, input logic [31:0] ins, input logic mr,
                     input logic [4:0] wr, input logic br, input logic ms,
                     input logic [4:0] exp);
    InstrID       = ins;
    IDEX_MemRead  = mr;
    IDEX_WriteReg = wr;
    BranchTaken   = br;
    MulDivStart   = ms;
    #1;
    chk(tag, {Stall, PCWrite, Flush, IDEX_Bubble, MulDivBusy}, exp);
    @(posedge Clk);
    #1;
  endtask

  logic [31:0] ADD8, IND, MFLO, MFHI, MULT, MULT8, DIV;

  initial begin
    ADD8  = rtyp(5'd8, 5'd10, 5'd9, 6'h20);
    IND   = rtyp(5'd1, 5'd2, 5'd3, 6'h20);
    MFLO  = rtyp(5'd0, 5'd0, 5'd3, 6'h12);
    MFHI  = rtyp(5'd0, 5'd0, 5'd3, 6'h10);
    MULT  = rtyp(5'd4, 5'd5, 5'd0, 6'h18);
    MULT8 = rtyp(5'd8, 5'd5, 5'd0, 6'h18);
    DIV   = rtyp(5'd4, 5'd5, 5'd0, 6'h1A);

    Reset = 1'b1;
    vec("rst_haz",   ADD8, 1, 8, 0, 1, OK);
    vec("rst_br",    ADD8, 1, 8, 1, 1, OK);
    Reset = 1'b0;

    // load-use basics
    vec("lu_rs",      ADD8, 1, 8, 0, 0, STL);
    vec("lu_hold",    ADD8, 1, 8, 0, 0, OK);
    vec("lu_after",   IND,  0, 0, 0, 0, OK);
    vec("lu_rt",      ADD8, 1, 10, 0, 0, STL);
    vec("lu_rt_rel",  IND,  0, 0, 0, 0, OK);
    vec("lu_r0",      rtyp(5'd0, 5'd0, 5'd9, 6'h20), 1, 0, 0, 0, OK);
    vec("addi_rtdst", ityp(6'h08, 5'd1, 5'd8), 1, 8, 0, 0, OK);
    vec("addi_rs",    ityp(6'h08, 5'd8, 5'd9), 1, 8, 0, 0, STL);
    vec("addi_rel",   IND,  0, 0, 0, 0, OK);
    vec("sw_rt",      ityp(6'h2B, 5'd1, 5'd8), 1, 8, 0, 0, STL);
    vec("sw_rel",     IND,  0, 0, 0, 0, OK);
    vec("noload",     ADD8, 0, 8, 0, 0, OK);

    // mult then mflo: busy 4 cycles, mflo stalled 3
    vec("md_start",   MULT, 0, 0, 0, 1, OK);
    vec("mflo_1",     MFLO, 0, 0, 0, 0, STL | BSY);
    vec("mflo_2",     MFLO, 0, 0, 0, 0, STL | BSY);
    vec("mflo_3",     MFLO, 0, 0, 0, 0, STL | BSY);
    vec("mflo_rel",   MFLO, 0, 0, 0, 0, OK | BSY);
    vec("md_done",    MFLO, 0, 0, 0, 0, OK);

    // branch beats load-use and cancels LDSTALL
    vec("br_lu",      ADD8, 1, 8, 1, 0, FLS);
    vec("br_idle",    ADD8, 1, 8, 0, 0, STL);
    vec("br_rel",     IND,  0, 0, 0, 0, OK);

    // load-use with MulDivStart: start deferred to retry; branch keeps counter
    vec("lu_md",      MULT8, 1, 8, 0, 1, STL);
    vec("lu_md_rty",  MULT8, 0, 0, 0, 1, OK);
    vec("rty_busy",   IND,  0, 0, 0, 0, OK | BSY);
    vec("br_busy",    MFHI, 0, 0, 1, 0, FLS | BSY);
    vec("mfhi_stl",   MFHI, 0, 0, 0, 0, STL | BSY);
    vec("mfhi_rel",   MFHI, 0, 0, 0, 0, OK | BSY);
    vec("busy_end",   IND,  0, 0, 0, 0, OK);

    // back-to-back mult/div
    vec("mm_first",   MULT, 0, 0, 0, 1, OK);
    vec("mm2_stl1",   DIV,  0, 0, 0, 1, STL | BSY);
    vec("mm2_stl2",   DIV,  0, 0, 0, 1, STL | BSY);
    vec("mm2_stl3",   DIV,  0, 0, 0, 1, STL | BSY);
    vec("mm2_go",     DIV,  0, 0, 0, 1, OK | BSY);
    for (int i = 0; i < 4; i++) vec("mm2_busy", IND, 0, 0, 0, 0, OK | BSY);
    vec("mm2_end",    IND,  0, 0, 0, 0, OK);

    // load-use while busy returns to BUSY
    vec("lb_start",   MULT, 0, 0, 0, 1, OK);
    vec("lb_haz",     ADD8, 1, 8, 0, 0, STL | BSY);
    vec("lb_ld",      IND,  0, 0, 0, 0, OK | BSY);
    vec("lb_mflo",    MFLO, 0, 0, 0, 0, STL | BSY);
    vec("lb_mflo_rl", MFLO, 0, 0, 0, 0, OK | BSY);
    vec("lb_end",     IND,  0, 0, 0, 0, OK);

    // reset mid-BUSY
    vec("rb_start",   MULT, 0, 0, 0, 1, OK);
    vec("rb_busy",    IND,  0, 0, 0, 0, OK | BSY);
    Reset = 1'b1;
    vec("rb_force",   MFLO, 0, 0, 0, 0, OK);
    Reset = 1'b0;
    vec("rb_mflo",    MFLO, 0, 0, 0, 0, OK);

    // reset mid-LDSTALL
    vec("rl_haz",     ADD8, 1, 8, 0, 0, STL);
    Reset = 1'b1;
    vec("rl_force",   ADD8, 1, 8, 0, 1, OK);
    Reset = 1'b0;
    vec("rl_redet",   ADD8, 1, 8, 0, 0, STL);
    vec("rl_rel",     IND,  0, 0, 0, 0, OK);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
